fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Drives the instruction memory from a program counter and delivers one fetched instruction per cycle to decode through a valid/ready IF/ID register. Handles decode back-pressure, branch/jump redirects with flush, an external halt request, and traps on misaligned or out-of-range fetch addresses. Sits between the instruction memory (asynchronous word-indexed read, `address >> 2`) and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `MEM_WORDS`, 1024, instruction memory depth in 32-bit words; legal fetch range 0 .. 4*MEM_WORDS-4
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_addr`  out  32  byte address to instruction memory (= PC register)
- `imem_instr`  in  32  instruction returned combinationally for `imem_addr`
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  32  redirect target (byte address)
- `halt`  in  1  level request: stop issuing new fetches
- `out_valid`  out  1  IF/ID register holds a valid instruction
- `out_ready`  in  1  decode accepts IF/ID contents this cycle
- `out_instr`  out  32  fetched instruction
- `out_pc`  out  32  address of `out_instr`
- `out_pc_plus4`  out  32  `out_pc + 4`
- `fault`  out  1  fetch fault latched
- `fault_pc`  out  32  offending address
- `fetch_count`  out  32  instructions delivered (handshakes completed)

## Operation
- States: `BOOT`, `RUN`, `HALTED`, `FAULT`.
- Reset: state `BOOT`, PC = `RESET_PC`, `out_valid`=0, `out_instr`/`out_pc`/`out_pc_plus4`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- `BOOT` -> `RUN` unconditionally after one cycle; no fetch in `BOOT`.
- Fetch slot free when `out_valid`=0 or `out_ready`=1. In `RUN` with free slot: IF/ID <= {`imem_instr`, PC, PC+4}, `out_valid`<=1, PC <= PC+4. Slot not free: PC and IF/ID hold (stall).
- Handshake `out_valid && out_ready`: `fetch_count` += 1 (wraps modulo 2^32). If no new fetch the same cycle, `out_valid`<=0.
- Priority per cycle: `redirect_valid` > fault check > `halt` > normal fetch.
- Redirect (any state except `FAULT`): PC <= `redirect_pc`, `out_valid`<=0 (IF/ID flushed, no fetch that cycle); a handshake completing that same cycle still counts.
- Fault check before each fetch and on redirect target: PC[1:0]!=0 or PC >= 4*MEM_WORDS -> state `FAULT`, `fault`<=1, `fault_pc`<=address, `out_valid`<=0. Misaligned redirect target faults on the following cycle's check. `FAULT` is left only by `rst`.
- `halt`=1 in `RUN` -> `HALTED`: no new fetch; a pending valid IF/ID entry remains until accepted. `halt`=0 in `HALTED` -> `RUN`, fetch resumes at current PC. Redirect in `HALTED` updates PC and flushes, state unchanged.
- PC arithmetic 32-bit, wraps; wrap is caught by range check.

## Timing
- Instruction for PC on `imem_addr` in cycle N appears on `out_instr` with `out_valid`=1 in cycle N+1.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- First valid output: second rising edge after `rst` release (BOOT, then fetch).
- Redirect in cycle N: `imem_addr`=`redirect_pc` in N+1, target instruction valid N+2 (one bubble).
- `fault` asserts the cycle after detection and stays high.
- `rst` mid-operation clears everything asynchronously; in-flight IF/ID contents discarded.

## Structure
- Shared package: state enum `fetch_state_t`, `XLEN`=32, `INSTR_BYTES`=4, `RESET_PC` default.
- Single module; PC register and IF/ID output register inline. No sub-module required; optional `fetch_fault_check` combinational helper for alignment/range.

## Test plan
- Reset, `out_ready`=1, memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193 -> `out_pc` 0,4,8,12 on consecutive cycles starting 2nd cycle after reset; `fetch_count`=4.
- Stall: `out_ready`=0 for 3 cycles with `out_pc`=4 -> `out_pc`/`out_instr` hold, `imem_addr` holds 8, `fetch_count` unchanged; release -> 8 next cycle.
- Redirect to 0x40 while `out_pc`=8 -> next cycle `out_valid`=0, `imem_addr`=0x40; following cycle `out_pc`=0x40, `out_pc_plus4`=0x44.
- Redirect to 0x42 -> `fault`=1, `fault_pc`=0x42, `out_valid`=0 permanently until `rst`; `rst` -> clean restart at `RESET_PC`.
- Sequential fetch to 0xFFC (MEM_WORDS=1024) -> 0xFFC delivered, then `fault`=1, `fault_pc`=0x1000.
- `halt`=1 with valid pending and `out_ready`=0 -> entry held, no PC advance; accept -> `out_valid`=0; `halt`=0 -> fetch resumes at held PC; simultaneous `halt` and redirect -> PC=target, state `HALTED`.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequencer state; plain constants keep the encoding stable for legacy tooling.
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StBoot   = 2'd0;
  localparam fetch_state_t StRun    = 2'd1;
  localparam fetch_state_t StHalted = 2'd2;
  localparam fetch_state_t StFault  = 2'd3;

endpackage

// File: rtl/fetch_sequencer_fault_check.sv
// Combinational legality check for a fetch address: word alignment and memory range.
module fetch_sequencer_fault_check
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic [XLEN-1:0] addr,
  output logic            bad
);

  // First byte address past the end of instruction memory.
  localparam logic [XLEN-1:0] Limit = XLEN'(MEM_WORDS * INSTR_BYTES);

  // A wrapped PC lands at a small value only after passing Limit, so it is caught here first.
  always_comb begin
    bad = (addr[1:0] != 2'b00) || (addr >= Limit);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter driven fetch stage feeding decode through a valid/ready IF/ID register.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     MEM_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, out_pc_q, out_pc_plus4_q;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] count_q;
  logic            pc_bad;
  logic            handshake;
  logic            slot_free;
  logic            fetch;

  fetch_sequencer_fault_check #(
    .MEM_WORDS(MEM_WORDS)
  ) u_fault_check (
    .addr(pc_q),
    .bad (pc_bad)
  );

  // Handshake and slot availability for the IF/ID register.
  always_comb begin
    handshake = valid_q && out_ready;
    slot_free = !valid_q || out_ready;
  end

  // Next-state: redirect beats fault check beats halt beats a normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q && !handshake;
    fault_pc_d = fault_pc_q;
    fetch      = 1'b0;
    case (state_q)
      StBoot: begin
        state_d = StRun;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end
      end
      StRun, StHalted: begin
        if (redirect_valid) begin
          // Target is checked next cycle, so a bad target faults one cycle late.
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = halt ? StHalted : StRun;
        end else if (pc_bad) begin
          state_d    = StFault;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
        end else if (halt) begin
          state_d = StHalted;
        end else if (state_q == StHalted) begin
          state_d = StRun;
        end else if (slot_free) begin
          fetch   = 1'b1;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      default: begin
        // Fault is sticky until reset.
        valid_d = 1'b0;
      end
    endcase
  end

  // State, PC, IF/ID register and delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StBoot;
      pc_q           <= RESET_PC;
      valid_q        <= 1'b0;
      instr_q        <= '0;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
      fault_pc_q     <= '0;
      count_q        <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      fault_pc_q <= fault_pc_d;
      if (fetch) begin
        instr_q        <= imem_instr;
        out_pc_q       <= pc_q;
        out_pc_plus4_q <= pc_q + XLEN'(INSTR_BYTES);
      end
      if (handshake) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_plus4_q;
  assign fault        = (state_q == StFault);
  assign fault_pc     = fault_pc_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;

  localparam int unsigned MemWords = 1024;
  localparam logic [31:0] Limit    = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc, fetch_count;

  logic [31:0] mem [MemWords];
  logic [31:0] prog [4];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < Limit) ? mem[imem_addr[11:2]] : 32'h0;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(MemWords)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  // Reference model: architectural view of the fetch stage.
  typedef enum {MBoot, MRun, MHalt, MFault} mmode_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mmode_t      m_mode     = MBoot;
  logic [31:0] m_pc       = 32'h0;
  bit          m_valid    = 1'b0;
  logic [31:0] m_count    = 32'h0;
  logic [31:0] m_fault_pc = 32'h0;
  exp_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= Limit);
  endfunction

  task automatic model_reset();
    m_mode     = MBoot;
    m_pc       = 32'h0;
    m_valid    = 1'b0;
    m_count    = 32'h0;
    m_fault_pc = 32'h0;
    exp_q.delete();
  endtask

  // Discard the pending IF/ID entry unless decode took it this cycle.
  task automatic flush(input bit hs);
    if (m_valid && !hs && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    bit   hs;
    exp_t e;
    hs = m_valid && out_ready;
    if (hs) m_count = m_count + 1;
    case (m_mode)
      MFault: ;
      MBoot: begin
        if (redirect_valid) begin
          flush(hs);
          m_pc = redirect_pc;
        end
        m_mode = MRun;
      end
      default: begin
        if (redirect_valid) begin
          flush(hs);
          m_pc   = redirect_pc;
          m_mode = halt ? MHalt : MRun;
        end else if (addr_bad(m_pc)) begin
          flush(hs);
          m_mode     = MFault;
          m_fault_pc = m_pc;
        end else if (halt || m_mode == MHalt) begin
          m_mode = halt ? MHalt : MRun;
          if (hs) m_valid = 1'b0;
        end else if (m_valid && !out_ready) begin
          // decode stalled: nothing moves
        end else begin
          e.pc    = m_pc;
          e.instr = mem[m_pc[11:2]];
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
        end
      end
    endcase
  endtask

  // Monitor: compare visible state every cycle, pop the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    check32("imem_addr", imem_addr, m_pc);
    check32("out_valid", 32'(out_valid), 32'(m_valid));
    check32("fault", 32'(fault), 32'(m_mode == MFault));
    check32("fault_pc", fault_pc, m_fault_pc);
    check32("fetch_count", fetch_count, m_count);
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: handshake pc %h but nothing expected", out_pc);
      end else begin
        e = exp_q.pop_front();
        check32("sb_pc", out_pc, e.pc);
        check32("sb_instr", out_instr, e.instr);
        check32("sb_pc_plus4", out_pc_plus4, e.pc + 4);
      end
    end
  end

  // One cycle: drive at the negedge, model at the posedge, return at the next negedge.
  task automatic step(input bit rdy, input bit h, input bit rv, input logic [31:0] rpc);
    out_ready      = rdy;
    halt           = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    out_ready      = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          rdy, h, rv;
    logic [31:0] tgt;
    int unsigned r;

    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193;
    for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];

    rst            = 1'b1;
    out_ready      = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    @(negedge clk);
    check32("rst_out_valid", 32'(out_valid), 32'h0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    check32("rst_out_pc_plus4", out_pc_plus4, 32'h0);
    check32("rst_fault", 32'(fault), 32'h0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check32("rst_fetch_count", fetch_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch of the first four words.
    step(1, 0, 0, 32'h0);
    check32("boot_no_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 32'h0);
      check32("seq_valid", 32'(out_valid), 32'h1);
      check32("seq_pc", out_pc, 32'(k * 4));
      check32("seq_instr", out_instr, prog[k]);
    end
    step(1, 0, 0, 32'h0);
    check32("seq_count4", fetch_count, 32'd4);

    // Decode stall with out_pc = 4, then redirect and a misaligned redirect.
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 32'h0);
      check32("stall_pc", out_pc, 32'h4);
      check32("stall_instr", out_instr, prog[1]);
      check32("stall_imem", imem_addr, 32'h8);
      check32("stall_count", fetch_count, 32'd1);
    end
    step(1, 0, 0, 32'h0);
    check32("unstall_pc", out_pc, 32'h8);
    step(1, 0, 1, 32'h40);
    check32("redir_bubble", 32'(out_valid), 32'h0);
    check32("redir_imem", imem_addr, 32'h40);
    check32("redir_count", fetch_count, 32'd3);
    step(1, 0, 0, 32'h0);
    check32("redir_pc", out_pc, 32'h40);
    check32("redir_pc_plus4", out_pc_plus4, 32'h44);
    step(1, 0, 1, 32'h42);
    step(1, 0, 0, 32'h0);
    check32("mis_fault", 32'(fault), 32'h1);
    check32("mis_fault_pc", fault_pc, 32'h42);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 32'h100);
      check32("mis_sticky_fault", 32'(fault), 32'h1);
      check32("mis_sticky_valid", 32'(out_valid), 32'h0);
    end
    do_reset();
    check32("restart_imem", imem_addr, 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check32("restart_pc", out_pc, 32'h0);
    check32("restart_fault", 32'(fault), 32'h0);

    // Run off the end of memory.
    step(1, 0, 1, 32'hFF0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 32'h0);
    check32("end_last_pc", out_pc, 32'hFFC);
    step(1, 0, 0, 32'h0);
    check32("end_fault", 32'(fault), 32'h1);
    check32("end_fault_pc", fault_pc, 32'h1000);

    // Halt with a pending entry, resume, then halt together with redirect.
    do_reset();
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 32'h0);
      check32("halt_hold_valid", 32'(out_valid), 32'h1);
      check32("halt_hold_pc", out_pc, 32'h0);
      check32("halt_hold_imem", imem_addr, 32'h4);
    end
    step(1, 1, 0, 32'h0);
    check32("halt_accept_valid", 32'(out_valid), 32'h0);
    check32("halt_accept_count", fetch_count, 32'd1);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check32("resume_pc", out_pc, 32'h4);
    step(1, 1, 1, 32'h80);
    check32("halt_redir_imem", imem_addr, 32'h80);
    check32("halt_redir_valid", 32'(out_valid), 32'h0);
    step(1, 1, 0, 32'h0);
    check32("halted_no_fetch", 32'(out_valid), 32'h0);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check32("halt_redir_pc", out_pc, 32'h80);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == MFault && $urandom_range(0, 3) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      h   = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      r   = $urandom_range(0, 19);
      if (r == 0) tgt = $urandom;
      else if (r == 1) tgt = {20'h0, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023))};
      else if (r < 5) tgt = 32'hFE0 + 32'($urandom_range(0, 7) * 4);
      else tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      step(rdy, h, rv, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
